// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin arbiter with BUSY watchdog.
package arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StBusy,
        StWait,
        StFree,
        StTimeout
    } state_e;

    // Channel index width; a single bit is kept even for N<=2.
    function automatic int unsigned idw(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cntw(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping N-1 -> 0.
module rr_picker import arb_pkg::*; #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = idw(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx
);

    localparam logic [IDW:0] NVAL = (IDW+1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;
    logic [IDW:0]   wrapped;

    // Rotating through a doubled vector puts position ptr at bit 0.
    assign dbl   = {req, req} >> ptr;
    assign rot   = dbl[N-1:0];
    assign found = |req;

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDW'(i);
            end
        end
    end

    assign sum     = {1'b0, ptr} + {1'b0, off};
    assign wrapped = sum - NVAL;
    assign idx     = (sum >= NVAL) ? wrapped[IDW-1:0] : sum[IDW-1:0];

endmodule

// File: rtl/arbiter_rr_tout.sv
// N-channel round-robin grant FSM with done/dly handshake and a BUSY watchdog.
module arbiter_rr_tout import arb_pkg::*; #(
    parameter int unsigned N           = 4,
    parameter int unsigned TOUT_CYCLES = 2,
    parameter int unsigned STICKY_TOUT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic               done,
    input  logic               dly,
    output logic [N-1:0]       gnt,
    output logic [idw(N)-1:0]  gnt_id,
    output logic               busy,
    output logic               tout,
    output logic [idw(N)-1:0]  tout_id
);

    localparam int unsigned     IDW    = idw(N);
    localparam int unsigned     CNTW   = cntw(TOUT_CYCLES);
    localparam logic [CNTW-1:0] TLAST  = (TOUT_CYCLES == 0) ? '0 : CNTW'(TOUT_CYCLES - 1);
    localparam logic [IDW-1:0]  LASTID = IDW'(N - 1);
    localparam logic [N-1:0]    ONE    = {{(N-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            found;
    logic [IDW-1:0]  pick;

    rr_picker #(
        .N   (N),
        .IDW (IDW)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .found (found),
        .idx   (pick)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    owner_d = pick;
                    ptr_d   = (pick == LASTID) ? '0 : pick + 1'b1;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // done wins over an expiring watchdog in the same cycle.
                if (done) begin
                    state_d = dly ? StWait : StFree;
                end else if (TOUT_CYCLES != 0) begin
                    if (cnt_q == TLAST) begin
                        state_d = StTimeout;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWait: begin
                if (!dly) begin
                    state_d = StFree;
                end
            end
            StFree: begin
                state_d = StIdle;
            end
            StTimeout: begin
                if (STICKY_TOUT == 0) begin
                    state_d = StFree;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they change with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            tout    <= 1'b0;
            tout_id <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt     <= (state_d == StBusy || state_d == StWait) ? (ONE << owner_d) : '0;
            gnt_id  <= owner_d;
            busy    <= (state_d != StIdle);
            tout    <= (state_d == StTimeout);
            tout_id <= (state_d == StTimeout) ? owner_d : '0;
        end
    end

endmodule

// File: tb/tb_arbiter_rr_tout.sv
// Bench: sticky and self-recovering arbiters driven in parallel against a behavioural model.
module tb_arbiter_rr_tout;

    localparam int N    = 4;
    localparam int TOUT = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req   = '0;
    logic       done  = 1'b0;
    logic       dly   = 1'b0;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] gnt_id_a, gnt_id_b, tout_id_a, tout_id_b;
    logic       busy_a, busy_b, tout_a, tout_b;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    arbiter_rr_tout #(.N(N), .TOUT_CYCLES(TOUT), .STICKY_TOUT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .dly(dly),
        .gnt(gnt_a), .gnt_id(gnt_id_a), .busy(busy_a), .tout(tout_a), .tout_id(tout_id_a)
    );

    arbiter_rr_tout #(.N(N), .TOUT_CYCLES(TOUT), .STICKY_TOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .dly(dly),
        .gnt(gnt_b), .gnt_id(gnt_id_b), .busy(busy_b), .tout(tout_b), .tout_id(tout_id_b)
    );

    // phase: 0 no owner, 1 owner working, 2 owner held by dly, 3 release gap, 4 timed out
    typedef struct {
        int phase;
        int owner;
        int last;
        int ptr;
        int stall;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.phase = 0;
        m.owner = 0;
        m.last  = 0;
        m.ptr   = 0;
        m.stall = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, logic [3:0] r, logic d, logic y, bit sticky);
        mdl_t n;
        bit   got;
        int   idx;
        n   = m;
        got = 1'b0;
        case (m.phase)
            0: begin
                for (int k = 0; k < N; k++) begin
                    idx = (m.ptr + k) % N;
                    if (!got && r[idx]) begin
                        got     = 1'b1;
                        n.owner = idx;
                        n.last  = idx;
                        n.ptr   = (idx + 1) % N;
                        n.stall = 0;
                        n.phase = 1;
                    end
                end
            end
            1: begin
                if (d) begin
                    n.phase = y ? 2 : 3;
                end else begin
                    n.stall = m.stall + 1;
                    if (TOUT != 0 && n.stall == TOUT) n.phase = 4;
                end
            end
            2: if (!y) n.phase = 3;
            3: n.phase = 0;
            4: if (!sticky) n.phase = 3;
            default: n.phase = 0;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] exp_gnt(mdl_t m);
        logic [3:0] g;
        g = '0;
        if (m.phase == 1 || m.phase == 2) g[m.owner] = 1'b1;
        return g;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mdl_reset();
            mb <= mdl_reset();
        end else begin
            ma <= mdl_step(ma, req, done, dly, 1'b1);
            mb <= mdl_step(mb, req, done, dly, 1'b0);
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_gnt_a", gnt_a, exp_gnt(ma));
            chk("model_gnt_id_a", gnt_id_a, ma.last);
            chk("model_busy_a", busy_a, ma.phase != 0);
            chk("model_tout_a", tout_a, ma.phase == 4);
            if (ma.phase == 4) chk("model_tout_id_a", tout_id_a, ma.owner);
            chk("model_gnt_b", gnt_b, exp_gnt(mb));
            chk("model_gnt_id_b", gnt_id_b, mb.last);
            chk("model_busy_b", busy_b, mb.phase != 0);
            chk("model_tout_b", tout_b, mb.phase == 4);
            if (mb.phase == 4) chk("model_tout_id_b", tout_id_b, mb.owner);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        dly   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_gnt", gnt_a, 0);
        chk("rst_gnt_id", gnt_id_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_tout", tout_a, 0);
        chk("rst_tout_id", tout_id_a, 0);
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // Normal path through WAIT.
        req = 4'b0001;
        tick();
        chk("t1_busy_gnt", gnt_a, 4'b0001);
        done = 1'b1; dly = 1'b1; req = '0;
        tick();
        chk("t1_wait_gnt", gnt_a, 4'b0001);
        done = 1'b0;
        tick();
        chk("t1_wait_hold", gnt_a, 4'b0001);
        dly = 1'b0;
        tick();
        chk("t1_free_gnt", gnt_a, 0);
        chk("t1_free_busy", busy_a, 1);
        tick();
        chk("t1_idle_busy", busy_a, 0);
        chk("t1_no_tout", tout_a, 0);

        // Watchdog: sticky on a, self-recovering on b.
        req = 4'b0010;
        tick();
        chk("t2_gnt", gnt_a, 4'b0010);
        req = '0;
        tick();
        chk("t2_gnt_hold", gnt_a, 4'b0010);
        tick();
        chk("t2_tout", tout_a, 1);
        chk("t2_tout_id", tout_id_a, 1);
        chk("t2_gnt_off", gnt_a, 0);
        chk("t3_tout_b", tout_b, 1);
        tick();
        chk("t2_sticky", tout_a, 1);
        chk("t3_free_tout", tout_b, 0);
        chk("t3_free_busy", busy_b, 1);
        tick();
        chk("t3_idle_busy", busy_b, 0);
        req = 4'b0100;
        tick();
        chk("t3_regrant", gnt_b, 4'b0100);
        chk("t2_stuck_gnt", gnt_a, 0);
        chk("t2_still_tout", tout_a, 1);
        done = 1'b1; req = '0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t2_rst_tout", tout_a, 0);
        chk("t2_rst_tout_id", tout_id_a, 0);
        chk("t2_rst_busy", busy_a, 0);
        chk("t2_rst_gnt_id", gnt_id_a, 0);
        tick();
        rst_n = 1'b1; done = 1'b0;

        // Round-robin with all requesters active.
        req = 4'b1111; done = 1'b1; dly = 1'b0;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("t4_rr_gnt", gnt_a, rr_exp[g]);
            if (g < 4) begin
                tick();
                chk("t4_gap1", gnt_a, 0);
                tick();
                chk("t4_gap2", gnt_a, 0);
            end
        end
        req = '0;
        tick();
        tick();

        // Pointer wrap and skip, then done coinciding with watchdog expiry.
        req = 4'b1000;
        tick();
        chk("t5_owner3", gnt_a, 4'b1000);
        req = 4'b0101;
        tick();
        tick();
        tick();
        chk("t5_wrap", gnt_a, 4'b0001);
        tick();
        tick();
        tick();
        chk("t5_skip", gnt_a, 4'b0100);
        done = 1'b0;
        tick();
        chk("t5_cnt1_gnt", gnt_a, 4'b0100);
        done = 1'b1;
        tick();
        chk("t5_done_wins", tout_a, 0);
        chk("t5_free_gnt", gnt_a, 0);
        chk("t5_free_busy", busy_a, 1);
        req = '0; done = 1'b0;
        tick();
        tick();

        // Asynchronous reset during WAIT.
        req = 4'b0001;
        tick();
        done = 1'b1; dly = 1'b1; req = '0;
        tick();
        chk("t6_wait_gnt", gnt_a, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_gnt", gnt_a, 0);
        chk("t6_async_busy", busy_a, 0);
        tick();
        rst_n = 1'b1; done = 1'b0; dly = 1'b0;
        req = 4'b1001;
        tick();
        chk("t6_ptr0", gnt_a, 4'b0001);
        req = '0; done = 1'b1;
        tick();
        tick();
        done = 1'b0;

        // Randomized episodes, each starting from reset.
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                req  = ($urandom % 4 == 0) ? 4'b0000 : 4'($urandom);
                done = ($urandom % 100) < 35;
                dly  = ($urandom % 100) < 50;
                tick();
            end
        end

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
